// File: rtl/pc_context_unit_if.sv
// pc_context_unit_if: fetch-control bus between the decode logic and the PC context unit
interface pc_context_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = $clog2(DEPTH + 1)
);
  logic [ADDR_W-1:0] next_pc;
  logic              ctx_call;
  logic [ADDR_W-1:0] ctx_target;
  logic              ctx_return;
  logic              wait_input;
  logic              insert;
  logic              halt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] saved_pc;
  logic [PTR_W-1:0]  depth;
  logic              in_program;
  logic              waiting;
  logic              halted;
  logic              overflow;
  logic              underflow;
  modport master (
    output next_pc, ctx_call, ctx_target, ctx_return, wait_input, insert, halt,
    input  pc, saved_pc, depth, in_program, waiting, halted, overflow, underflow
  );
  modport slave (
    input  next_pc, ctx_call, ctx_target, ctx_return, wait_input, insert, halt,
    output pc, saved_pc, depth, in_program, waiting, halted, overflow, underflow
  );
endinterface

// File: rtl/pc_context_unit.sv
// pc_context_unit: program counter with a DEPTH-deep return stack, input-wait and halt states
module pc_context_unit #(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int PTR_W = $clog2(DEPTH + 1)
) (
  input logic CLK,
  input logic reset,
  pc_context_unit_if.slave bus
);
  typedef enum logic [1:0] {RUN, WAIT_IN, HALTED} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, top;
  logic [ADDR_W-1:0] stack_q [DEPTH];
  logic [ADDR_W-1:0] stack_d [DEPTH];
  logic [PTR_W-1:0] depth_q, depth_d;
  logic ovf_q, ovf_d, unf_q, unf_d, insert_q, insert_rise;
  assign insert_rise = bus.insert & ~insert_q;
  // top-of-stack entry, zero when the stack is empty
  always_comb begin
    top = '0;
    for (int k = 0; k < DEPTH; k++)
      if (PTR_W'(k + 1) == depth_q) top = stack_q[k];
  end
  // next-state: one action per RUN cycle, priority halt > wait > call > return > sequential
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    depth_d = depth_q;
    stack_d = stack_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    case (state_q)
      RUN:
        if (bus.halt) state_d = HALTED;
        else if (bus.wait_input) begin
          if (insert_rise) pc_d = bus.next_pc;
          else state_d = WAIT_IN;
        end else if (bus.ctx_call) begin
          if (depth_q < PTR_W'(DEPTH)) begin
            for (int k = 0; k < DEPTH; k++)
              if (PTR_W'(k) == depth_q) stack_d[k] = bus.next_pc;
            depth_d = depth_q + 1'b1;
            pc_d = bus.ctx_target;
          end else begin
            ovf_d = 1'b1;
            pc_d = bus.next_pc;
          end
        end else if (bus.ctx_return) begin
          if (depth_q != '0) begin
            for (int k = 0; k < DEPTH; k++)
              if (PTR_W'(k + 1) == depth_q) stack_d[k] = '0;
            depth_d = depth_q - 1'b1;
            pc_d = top;
          end else begin
            unf_d = 1'b1;
            pc_d = bus.next_pc;
          end
        end else pc_d = bus.next_pc;
      WAIT_IN:
        if (insert_rise) begin
          pc_d = bus.next_pc;
          state_d = RUN;
        end
      default: ;
    endcase
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      depth_q <= '0;
      stack_q <= '{default: '0};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      insert_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      depth_q <= depth_d;
      stack_q <= stack_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      insert_q <= bus.insert;
    end
  end
  assign bus.pc = pc_q;
  assign bus.saved_pc = top;
  assign bus.depth = depth_q;
  assign bus.in_program = depth_q != '0;
  assign bus.waiting = state_q == WAIT_IN;
  assign bus.halted = state_q == HALTED;
  assign bus.overflow = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_pc_context_unit.sv
// tb_pc_context_unit: directed vector table plus hand sequences for wait, halt and async reset
module tb_pc_context_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  pc_context_unit_if #(.ADDR_W(32), .DEPTH(4)) bus ();
  pc_context_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (.CLK(clk), .reset(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic call, ret, wt, ins, hlt;
    logic [31:0] np, tgt, e_pc, e_saved;
    logic [2:0] e_depth;
    logic e_ovf, e_unf, e_wait;
  } vec_t;
  vec_t vq[$];
  function automatic vec_t mk(logic call, logic ret, logic wt, logic ins, logic hlt,
                              logic [31:0] np, logic [31:0] tgt, logic [31:0] e_pc,
                              logic [31:0] e_saved, logic [2:0] e_depth,
                              logic e_ovf, logic e_unf, logic e_wait);
    vec_t v;
    v.call = call; v.ret = ret; v.wt = wt; v.ins = ins; v.hlt = hlt;
    v.np = np; v.tgt = tgt; v.e_pc = e_pc; v.e_saved = e_saved; v.e_depth = e_depth;
    v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_wait = e_wait;
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(logic call, logic ret, logic wt, logic ins, logic hlt, logic [31:0] np, logic [31:0] tgt);
    bus.ctx_call = call; bus.ctx_return = ret; bus.wait_input = wt;
    bus.insert = ins; bus.halt = hlt; bus.next_pc = np; bus.ctx_target = tgt;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(string tag, logic [31:0] e_pc, logic [31:0] e_saved, logic [2:0] e_depth,
                         logic e_ovf, logic e_unf, logic e_wait, logic e_halt);
    chk({tag, ".pc"}, bus.pc, e_pc);
    chk({tag, ".saved"}, bus.saved_pc, e_saved);
    chk({tag, ".depth"}, 32'(bus.depth), 32'(e_depth));
    chk({tag, ".inprog"}, 32'(bus.in_program), 32'(e_depth != 0));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(e_ovf));
    chk({tag, ".unf"}, 32'(bus.underflow), 32'(e_unf));
    chk({tag, ".wait"}, 32'(bus.waiting), 32'(e_wait));
    chk({tag, ".halt"}, 32'(bus.halted), 32'(e_halt));
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    //         call ret wt ins hlt  np        tgt       e_pc      e_saved   d  ovf unf wait
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h004, 32'h000, 32'h004, 32'h000, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h008, 32'h000, 32'h008, 32'h000, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h00C, 32'h000, 32'h00C, 32'h000, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h010, 32'h000, 32'h010, 32'h000, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h014, 32'h100, 32'h100, 32'h014, 1, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 32'h104, 32'h000, 32'h014, 32'h000, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h018, 32'h200, 32'h200, 32'h018, 1, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h204, 32'h300, 32'h300, 32'h204, 2, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h304, 32'h400, 32'h400, 32'h304, 3, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h404, 32'h500, 32'h500, 32'h404, 4, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h504, 32'h600, 32'h504, 32'h404, 4, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 32'h508, 32'h000, 32'h404, 32'h304, 3, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 32'h408, 32'h000, 32'h304, 32'h204, 2, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 32'h308, 32'h000, 32'h204, 32'h018, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 32'h208, 32'h000, 32'h018, 32'h000, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 32'h01C, 32'h000, 32'h01C, 32'h000, 0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h020, 32'h000, 32'h020, 32'h000, 0, 1, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h024, 32'h700, 32'h700, 32'h024, 1, 1, 1, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, 32'h704, 32'h800, 32'h800, 32'h704, 2, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 32'h804, 32'h000, 32'h704, 32'h024, 1, 1, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 32'h708, 32'h000, 32'h024, 32'h000, 0, 1, 1, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 32'h030, 32'h000, 32'h030, 32'h000, 0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h020, 32'h000, 32'h020, 32'h000, 0, 1, 1, 0));
    #2;
    chk_all("reset", 32'h0, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].call, vq[i].ret, vq[i].wt, vq[i].ins, vq[i].hlt, vq[i].np, vq[i].tgt);
      step();
      chk_all($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_saved, vq[i].e_depth,
              vq[i].e_ovf, vq[i].e_unf, vq[i].e_wait, 1'b0);
    end
    drive(0, 0, 1, 0, 0, 32'h024, 32'h0);
    step();
    chk_all("wait_enter", 32'h020, 32'h0, 0, 1, 1, 1, 0);
    drive(1, 1, 1, 0, 0, 32'h024, 32'h900);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("wait_hold%0d.pc", i), bus.pc, 32'h020);
      chk($sformatf("wait_hold%0d.wait", i), 32'(bus.waiting), 32'd1);
    end
    chk("wait_hold.depth", 32'(bus.depth), 32'd0);
    drive(0, 0, 1, 1, 0, 32'h024, 32'h0);
    step();
    chk_all("wait_release", 32'h024, 32'h0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("ins_held%0d.pc", i), bus.pc, 32'h024);
    end
    drive(0, 0, 0, 0, 0, 32'h028, 32'h0);
    step();
    chk_all("ins_low", 32'h024, 32'h0, 0, 1, 1, 1, 0);
    drive(0, 0, 0, 1, 0, 32'h028, 32'h0);
    step();
    chk_all("wait_exit", 32'h028, 32'h0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 32'h040, 32'h0);
    step();
    chk("pre_halt.pc", bus.pc, 32'h040);
    drive(0, 0, 0, 0, 1, 32'h044, 32'h0);
    step();
    chk_all("halt", 32'h040, 32'h0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 6; i++) begin
      drive(i[0], ~i[0], i[1], i[0], 0, 32'h050, 32'hA00);
      step();
      chk_all($sformatf("halted%0d", i), 32'h040, 32'h0, 0, 1, 1, 0, 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 32'h0, 32'h0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 32'h004, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 32'h004, 32'hB00);
    step();
    chk_all("post_reset_call", 32'hB00, 32'h004, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 32'hB04, 32'h0);
    step();
    chk("ctx_wait.wait", 32'(bus.waiting), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("reset_mid_ctx", 32'h0, 32'h0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
